// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 receiver and held-key decoder (optional WASD keys: PS2_WASD_EN)
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_CHECK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          accept, reject, timeout;

  logic          ext, brk;
  logic          k_up, k_down, k_left, k_right, k_ent_main, k_ent_kp, k_space;
`ifdef PS2_WASD_EN
  logic          k_w, k_a, k_s, k_d;
`endif

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples;
  // the strobe marks a completed 1->0 flip.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        flt_cnt  <= '0;
        strobe   <= ~clk_s;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      if ((state == S_DATA || state == S_PARITY || state == S_STOP) && !strobe)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
    end
  end

  // The stop bit is judged as it arrives, so results register into the CHECK cycle.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    accept    = 1'b0;
    reject    = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe && !dat_s) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        if (strobe) begin
          shreg_n   = {dat_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          par_bit_n = dat_s;
          state_n   = S_STOP;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_STOP: begin
        if (strobe) begin
          state_n = S_CHECK;
          if (dat_s && ((^shreg) ^ par_bit)) accept = 1'b1;
          else                               reject = 1'b1;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_CHECK: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      k_up       <= 1'b0;
      k_down     <= 1'b0;
      k_left     <= 1'b0;
      k_right    <= 1'b0;
      k_ent_main <= 1'b0;
      k_ent_kp   <= 1'b0;
      k_space    <= 1'b0;
`ifdef PS2_WASD_EN
      k_w        <= 1'b0;
      k_a        <= 1'b0;
      k_s        <= 1'b0;
      k_d        <= 1'b0;
`endif
    end else begin
      code_valid <= accept;
      frame_err  <= reject | timeout;
      if (reject || timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (accept) begin
        scan_code <= shreg;
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          case ({ext, shreg})
            9'h175:  k_up       <= ~brk;
            9'h172:  k_down     <= ~brk;
            9'h16B:  k_left     <= ~brk;
            9'h174:  k_right    <= ~brk;
            9'h05A:  k_ent_main <= ~brk;
            9'h15A:  k_ent_kp   <= ~brk;
            9'h029:  k_space    <= ~brk;
`ifdef PS2_WASD_EN
            9'h01D:  k_w        <= ~brk;
            9'h01C:  k_a        <= ~brk;
            9'h01B:  k_s        <= ~brk;
            9'h023:  k_d        <= ~brk;
`endif
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PS2_WASD_EN
  assign up    = k_up    | k_w;
  assign down  = k_down  | k_s;
  assign left  = k_left  | k_a;
  assign right = k_right | k_d;
`else
  assign up    = k_up;
  assign down  = k_down;
  assign left  = k_left;
  assign right = k_right;
`endif
  assign enter = k_ent_main | k_ent_kp;
  assign space = k_space;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int H           = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, enter, space;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;
  logic [5:0] keys;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv0, fe0;
  logic exp_wasd;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  assign keys = {up, down, left, right, enter, space};

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err)  fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (5) @(posedge clk);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
      end else begin
        repeat (3) @(posedge clk);
      end
      repeat (H - 8) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par = 1'b0,
                       input bit bad_stop = 1'b0, input bit glitch = 1'b0);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11, glitch);
    ps2_data = 1'b1;
    repeat (3 * H) @(posedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
`ifdef PS2_WASD_EN
    exp_wasd = 1'b1;
`else
    exp_wasd = 1'b0;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_scan", 32'(scan_code), 32'h0);
    check("rst_pulses", {30'd0, code_valid, frame_err}, 32'h0);
    reset = 1'b1;
    repeat (20) @(posedge clk);

    snap();
    frame(8'h29);
    check("space_make", 32'(keys), 32'h01);
    check("space_scan", 32'(scan_code), 32'h29);
    check("space_cv_once", 32'(cv_cnt - cv0), 32'd1);
    check("space_no_err", 32'(fe_cnt - fe0), 32'd0);
    snap();
    frame(8'hF0); frame(8'h29);
    check("space_break", 32'(space), 32'h0);
    check("break_cv2", 32'(cv_cnt - cv0), 32'd2);

    frame(8'hE0); frame(8'h75);
    check("up_make", 32'(keys), 32'h20);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    check("up_break", 32'(up), 32'h0);
    frame(8'h75);
    check("kp8_no_up", 32'(keys), 32'h0);

    frame(8'h5A);
    check("enter_main", 32'(enter), 32'h1);
    frame(8'hE0); frame(8'h5A);
    check("enter_both", 32'(enter), 32'h1);
    frame(8'hF0); frame(8'h5A);
    check("enter_kp_held", 32'(enter), 32'h1);
    frame(8'hE0); frame(8'hF0); frame(8'h5A);
    check("enter_off", 32'(enter), 32'h0);

    snap();
    frame(8'h29, 1'b1);
    check("par_err", 32'(fe_cnt - fe0), 32'd1);
    check("par_no_cv", 32'(cv_cnt - cv0), 32'd0);
    check("par_space", 32'(space), 32'h0);
    check("par_scan_kept", 32'(scan_code), 32'h5A);
    snap();
    frame(8'h29, 1'b0, 1'b1);
    check("stop_err", 32'(fe_cnt - fe0), 32'd1);
    check("stop_no_cv", 32'(cv_cnt - cv0), 32'd0);

    frame(8'hE0); frame(8'h29, 1'b1); frame(8'h75);
    check("err_clears_ext", 32'(up), 32'h0);

    snap();
    send_bits(11'b000_0000_1010, 5, 1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYC + 100) @(posedge clk);
    check("timeout_err", 32'(fe_cnt - fe0), 32'd1);
    check("timeout_no_cv", 32'(cv_cnt - cv0), 32'd0);
    snap();
    frame(8'hE0); frame(8'h74);
    check("right_after_to", 32'(keys), 32'h04);
    check("right_cv2", 32'(cv_cnt - cv0), 32'd2);

    frame(8'hE0); frame(8'h6B, 1'b0, 1'b0, 1'b1);
    check("glitch_left", 32'(left), 32'h1);
    check("glitch_scan", 32'(scan_code), 32'h6B);
    frame(8'hE0); frame(8'hF0); frame(8'h6B);

    frame(8'hE0); frame(8'h72);
    frame(8'hE0); frame(8'h72);
    check("typematic_down", 32'(keys), 32'h14);
    frame(8'hF0); frame(8'h29);
    check("break_unheld", 32'(keys), 32'h14);
    frame(8'hE0); frame(8'hF0); frame(8'h72);
    check("down_break", 32'(keys), 32'h04);

    snap();
    frame(8'h1D);
    check("w_key", 32'(up), 32'(exp_wasd));
    check("w_cv", 32'(cv_cnt - cv0), 32'd1);
    frame(8'hF0); frame(8'h1D);

    frame(8'h29);
    send_bits(11'b000_0000_0110, 4, 1'b0);
    reset = 1'b0;
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrst_keys", 32'(keys), 32'h0);
    check("midrst_scan", 32'(scan_code), 32'h0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    snap();
    frame(8'h29);
    check("postrst_keys", 32'(keys), 32'h01);
    check("postrst_cv", 32'(cv_cnt - cv0), 32'd1);
    check("postrst_err", 32'(fe_cnt - fe0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames (scan code set 2) and decodes them into held key levels for the game controller: up, down, left, right, enter and space.
- Each output is a level that is high while the key is physically held.
- Sits between the board's PS/2 pins and the controller's key inputs, in the 25 MHz game clock domain.

Parameters:
FILTER_LEN, 8, consecutive equal samples of synchronized ps2_clk required to change its filtered value
TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (2 ms at 25 MHz)

Ports:
clk  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-low reset (asserted when 0)
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk
ps2_data  input  1  raw PS/2 data, asynchronous to clk
up  output  1  level: up arrow held
down  output  1  level: down arrow held
left  output  1  level: left arrow held
right  output  1  level: right arrow held
enter  output  1  level: Enter held (main or keypad)
space  output  1  level: Space held
scan_code  output  8  last accepted data byte
code_valid  output  1  1-cycle pulse: frame accepted
frame_err  output  1  1-cycle pulse: frame rejected or timed out

Behaviour:
- Reset: all outputs 0, scan_code 8'h00, receiver in IDLE, prefix flags cleared. Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - ps2_clk is then filtered: the filtered value changes only after FILTER_LEN identical samples.
  - A falling edge of the filtered clock is a sample strobe. ps2_data is sampled at the strobe.
- Receiver FSM:
  - IDLE: on strobe, if data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE with no error.
  - DATA: on each strobe, shift data in LSB first. After 8 bits, go to PARITY.
  - PARITY: on strobe, capture the parity bit and go to STOP.
  - STOP: on strobe, capture the stop bit and go to CHECK.
  - CHECK (1 cycle): the frame is accepted if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity). Accept: scan_code updated, code_valid=1. Reject: frame_err=1 and prefix flags cleared. Then return to IDLE.
  - Timeout: in DATA, PARITY or STOP, a counter clears on each strobe. Reaching TIMEOUT_CYC pulses frame_err, clears prefix flags and returns to IDLE.
- Decoder, evaluated in the CHECK cycle of an accepted frame:
  - 8'hE0 sets ext. 8'hF0 sets brk. Neither changes any key output.
  - Any other byte forms a code of {ext, byte}. The key bit is set to ~brk, then ext and brk clear.
  - Key map: up = E0 75; down = E0 72; left = E0 6B; right = E0 74; enter = 5A or E0 5A; space = 29.
  - Non-extended 75/72/6B/74 (keypad digits) do not drive the arrow outputs.
  - Unmapped codes: code_valid still pulses, flags clear, key outputs unchanged.
  - enter is the OR of two tracked bits (main and keypad), so releasing one does not clear the other while it is still held.
- Latency: key outputs and code_valid change 1 cycle after the stop-bit strobe, both in the same cycle.
- Typematic repeat (repeated make code): the level stays 1, with no glitch.
- Multiple keys are tracked independently. A break for a key that is not held leaves it at 0.
- E1 (Pause) sequences decode as unmapped codes and have no effect on the key outputs.

Optional Feature:
- Macro: PS2_WASD_EN.
- Defined: W (1D), A (1C), S (1B) and D (23) drive up, left, down and right, each with its own tracked bit. Each direction output is the OR of its arrow bit and its letter bit.
- Undefined: these codes are unmapped and only arrows drive the direction outputs.

Test Plan:
- Frame 8'h29 with correct parity and stop -> space=1, scan_code=8'h29, code_valid pulses once. Then F0, 29 -> space=0.
- Sequence E0 75 -> up=1. Then E0 F0 75 -> up=0. Non-extended 75 alone -> up stays 0.
- Press 5A, then E0 5A, then release 5A (F0 5A) -> enter stays 1. Then E0 F0 5A -> enter=0.
- Frame 8'h29 with wrong parity -> frame_err pulses, space stays 0. Frame with stop=0 -> frame_err, no code_valid.
- Start bit plus 4 bits, then no clock for TIMEOUT_CYC cycles -> frame_err pulses. A following valid E0 74 frame -> right=1.
- ps2_clk glitch shorter than FILTER_LEN cycles during a frame -> no extra bit shifted, frame decodes correctly. Reset asserted mid-frame -> all outputs 0, next frame decodes normally.
